fcdnn_dma64_mem_server: RTL and testbench
=========================================

Name: fcdnn_dma64_mem_server

Overview:
Memory-side DMA responder that serves the FCDNN accelerator wrapper's 64-bit DMA read and write interfaces from a local 64-bit scratchpad. It sits directly downstream of the wrapper's dma_* ports; its ctrl/chnl ports connect 1:1 to them. A host port preloads the input words (28 beats) and reads back the result words (15 beats). Independent read and write engines share the memory array; the memory has one read port and one write port.

Parameters:
MEM_WORDS, 2048, scratchpad depth in 64-bit words
ADDR_W, 11, log2(MEM_WORDS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rd_base  in  ADDR_W  word offset added to read ctrl index
wr_base  in  ADDR_W  word offset added to write ctrl index
dma_read_ctrl_valid  in  1  read request valid
dma_read_ctrl_data_index  in  32  start word index
dma_read_ctrl_data_length  in  32  beat count
dma_read_ctrl_data_size  in  3  beat size code; 3 = 64-bit
dma_read_ctrl_ready  out  1  read request accepted
dma_read_chnl_valid  out  1  read beat valid
dma_read_chnl_data  out  64  read beat
dma_read_chnl_ready  in  1  consumer ready
dma_write_ctrl_valid  in  1  write request valid
dma_write_ctrl_data_index  in  32  start word index
dma_write_ctrl_data_length  in  32  beat count
dma_write_ctrl_data_size  in  3  beat size code
dma_write_ctrl_ready  out  1  write request accepted
dma_write_chnl_valid  in  1  write beat valid
dma_write_chnl_data  in  64  write beat
dma_write_chnl_ready  out  1  write beat accepted
host_en  in  1  host access strobe; honoured only while busy=0
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host word address
host_wdata  in  64  host write data
host_rdata  out  64  host read data, valid 1 cycle after a host read
busy  out  1  either engine is not idle
rd_done  out  1  1-cycle pulse when a read transfer completes
wr_done  out  1  1-cycle pulse when a write transfer completes
err  out  1  sticky error flag
err_clr  in  1  clears err

Behaviour:
- Reset (rst=0, async): both engines idle. All outputs 0 except dma_read_ctrl_ready=1 and dma_write_ctrl_ready=1. Memory contents are not reset.
- Read FSM R_IDLE/R_FETCH/R_STREAM:
  - R_IDLE: ctrl_ready=1. On ctrl_valid, latch addr=rd_base+index[ADDR_W-1:0] and rem=length.
  - length=0: stay in R_IDLE and pulse rd_done next cycle.
  - Otherwise go to R_FETCH; ctrl_ready=0 until the engine returns to idle.
  - Bad request (size!=3, or index+length > MEM_WORDS-rd_base, computed in 33 bits): set err; still stream rem beats, with data forced to 0.
  - R_FETCH: synchronous memory read at addr. Next cycle go to R_STREAM with chnl_valid=1 and chnl_data=mem[addr].
  - R_STREAM: valid and data are held stable while chnl_ready=0.
  - On ready with rem=1: valid=0, rd_done pulse, go to R_IDLE.
  - On ready otherwise: addr+1, rem-1, valid=0, go to R_FETCH.
  - Throughput is 1 beat per 2 cycles. Latency from ctrl handshake to first valid is 2 cycles.
- Write FSM W_IDLE/W_DATA:
  - W_IDLE: ctrl_ready=1. Latch addr and rem as for reads.
  - length=0: pulse wr_done.
  - W_DATA: chnl_ready=1. Each cycle with chnl_valid=1 writes mem[addr] (suppressed if the request was bad), then addr+1, rem-1.
  - Last beat: chnl_ready=0 next cycle, wr_done pulse, go to W_IDLE.
  - Bad request: set err, accept and drop all rem beats so the accelerator never deadlocks.
- Same-cycle engine write and engine read to one address: the read returns the old data (read-first).
- Host port: host_en with busy=1 is ignored, with no rdata update. Host write has priority on the write port only while both engines are idle.
- err: set by any bad request. err_clr clears it; a set and a clear in the same cycle leaves err=1.
- Address wrap: addr is never allowed to exceed MEM_WORDS-1. Out-of-range requests take the bad path; there is no silent wrap.
- Length is held in 32 bits; rem=length-1 compare is full width.

Decomposition:
- Package fcdnn_dma_pkg holds the shared definitions:
  - DMA_SIZE_64=3'd3
  - NUM_BEATS_RD=28, NUM_BEATS_WR=15
  - rd_state_t and wr_state_t enums
- Sub-module fcdnn_dma64_sram: 1R1W synchronous, read-first 64-bit memory, instantiated once.

Test Plan:
- Host-write words 0..27 with value 0xA5A5_0000_0000_0000+i; read request index 0, length 28, size 3, ready always 1 -> 28 beats in order, first valid 2 cycles after the handshake, rd_done once, err=0.
- Read with chnl_ready toggling 1-0-0-1 -> each beat held stable while ready=0; no beat lost or duplicated (scoreboard count 28).
- Write request index 100, length 15, wr_base=0; beats 0x1..0xF -> host reads of 100..114 return 0x1..0xF; wr_done once.
- Read length 0 -> no chnl_valid, rd_done pulse; read size=2 length 4 -> err=1, 4 zero beats; then err_clr -> err=0.
- Write index 2040, length 15, MEM_WORDS=2048 -> err=1, 15 beats accepted, memory at 2040..2047 unchanged.
- Assert rst low mid-R_STREAM (beat 10) -> outputs at reset values immediately; new request index 0 length 28 after release streams correctly from word 0.

Source files
------------

// File: rtl/fcdnn_dma_pkg.sv
// Shared definitions for the FCDNN 64-bit DMA memory server.
// Size codes, beat counts, engine state encodings and request check.
package fcdnn_dma_pkg;

  localparam logic [2:0] DMA_SIZE_64 = 3'd3;
  localparam int NUM_BEATS_RD = 28;
  localparam int NUM_BEATS_WR = 15;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_STREAM
  } rd_state_t;

  typedef enum logic {
    W_IDLE,
    W_DATA
  } wr_state_t;

  // lim is MEM_WORDS - base; the sum is taken in 33 bits so it cannot wrap
  function automatic logic req_bad(
    input logic [31:0] idx,
    input logic [31:0] len,
    input logic [2:0]  size,
    input logic [32:0] lim
  );
    logic [32:0] last;
    last = {1'b0, idx} + {1'b0, len};
    return (size != DMA_SIZE_64) || (last > lim);
  endfunction

endpackage

// File: rtl/fcdnn_dma64_sram.sv
// 1R1W synchronous 64-bit scratchpad, read-first on address collision.
// Read data register holds its value until the next read enable.
module fcdnn_dma64_sram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fcdnn_dma64_mem_server.sv
// DMA responder serving the accelerator's 64-bit read/write channels
// from a local scratchpad, with a host port for preload and readback.
module fcdnn_dma64_mem_server
  import fcdnn_dma_pkg::*;
#(
  parameter int MEM_WORDS = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              dma_read_ctrl_valid,
  input  logic [31:0]       dma_read_ctrl_data_index,
  input  logic [31:0]       dma_read_ctrl_data_length,
  input  logic [2:0]        dma_read_ctrl_data_size,
  output logic              dma_read_ctrl_ready,
  output logic              dma_read_chnl_valid,
  output logic [63:0]       dma_read_chnl_data,
  input  logic              dma_read_chnl_ready,
  input  logic              dma_write_ctrl_valid,
  input  logic [31:0]       dma_write_ctrl_data_index,
  input  logic [31:0]       dma_write_ctrl_data_length,
  input  logic [2:0]        dma_write_ctrl_data_size,
  output logic              dma_write_ctrl_ready,
  input  logic              dma_write_chnl_valid,
  input  logic [63:0]       dma_write_chnl_data,
  output logic              dma_write_chnl_ready,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [63:0]       host_wdata,
  output logic [63:0]       host_rdata,
  output logic              busy,
  output logic              rd_done,
  output logic              wr_done,
  output logic              err,
  input  logic              err_clr
);

  rd_state_t         rstate_q;
  wr_state_t         wstate_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [31:0]       rrem_q, wrem_q;
  logic              rbad_q, wbad_q;
  logic              rvalid_q, rctrl_rdy_q, rd_done_q;
  logic              wchnl_rdy_q, wctrl_rdy_q, wr_done_q;
  logic              err_q;

  logic [ADDR_W-1:0] raddr_d, waddr_d;
  logic [32:0]       rd_lim, wr_lim;
  logic              rd_bad, wr_bad, rd_hs, wr_hs, wfire;
  logic              host_ok, mem_re, mem_we;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [63:0]       mem_wdata, mem_rdata;

  assign raddr_d = rd_base + dma_read_ctrl_data_index[ADDR_W-1:0];
  assign waddr_d = wr_base + dma_write_ctrl_data_index[ADDR_W-1:0];
  assign rd_lim  = 33'(MEM_WORDS) - 33'(rd_base);
  assign wr_lim  = 33'(MEM_WORDS) - 33'(wr_base);
  assign rd_bad  = req_bad(dma_read_ctrl_data_index,
                           dma_read_ctrl_data_length,
                           dma_read_ctrl_data_size, rd_lim);
  assign wr_bad  = req_bad(dma_write_ctrl_data_index,
                           dma_write_ctrl_data_length,
                           dma_write_ctrl_data_size, wr_lim);
  assign rd_hs   = dma_read_ctrl_valid && (rstate_q == R_IDLE);
  assign wr_hs   = dma_write_ctrl_valid && (wstate_q == W_IDLE);
  assign wfire   = (wstate_q == W_DATA) && dma_write_chnl_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q    <= R_IDLE;
      raddr_q     <= '0;
      rrem_q      <= '0;
      rbad_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rctrl_rdy_q <= 1'b1;
      rd_done_q   <= 1'b0;
    end else begin
      rd_done_q <= 1'b0;
      unique case (rstate_q)
        R_IDLE: if (dma_read_ctrl_valid) begin
          raddr_q <= raddr_d;
          rrem_q  <= dma_read_ctrl_data_length;
          rbad_q  <= rd_bad;
          if (dma_read_ctrl_data_length == 32'd0) begin
            rd_done_q <= 1'b1;
          end else begin
            rstate_q    <= R_FETCH;
            rctrl_rdy_q <= 1'b0;
          end
        end
        R_FETCH: begin
          rstate_q <= R_STREAM;
          rvalid_q <= 1'b1;
        end
        R_STREAM: if (dma_read_chnl_ready) begin
          rvalid_q <= 1'b0;
          if (rrem_q == 32'd1) begin
            rd_done_q   <= 1'b1;
            rstate_q    <= R_IDLE;
            rctrl_rdy_q <= 1'b1;
          end else begin
            raddr_q  <= raddr_q + 1'b1;
            rrem_q   <= rrem_q - 32'd1;
            rstate_q <= R_FETCH;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q    <= W_IDLE;
      waddr_q     <= '0;
      wrem_q      <= '0;
      wbad_q      <= 1'b0;
      wchnl_rdy_q <= 1'b0;
      wctrl_rdy_q <= 1'b1;
      wr_done_q   <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (wstate_q)
        W_IDLE: if (dma_write_ctrl_valid) begin
          waddr_q <= waddr_d;
          wrem_q  <= dma_write_ctrl_data_length;
          wbad_q  <= wr_bad;
          if (dma_write_ctrl_data_length == 32'd0) begin
            wr_done_q <= 1'b1;
          end else begin
            wstate_q    <= W_DATA;
            wchnl_rdy_q <= 1'b1;
            wctrl_rdy_q <= 1'b0;
          end
        end
        W_DATA: if (dma_write_chnl_valid) begin
          waddr_q <= waddr_q + 1'b1;
          wrem_q  <= wrem_q - 32'd1;
          if (wrem_q == 32'd1) begin
            wchnl_rdy_q <= 1'b0;
            wr_done_q   <= 1'b1;
            wstate_q    <= W_IDLE;
            wctrl_rdy_q <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // a set wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else err_q <= (err_q && !err_clr) ||
                  (rd_hs && rd_bad) || (wr_hs && wr_bad);
  end

  assign busy      = (rstate_q != R_IDLE) || (wstate_q != W_IDLE);
  assign host_ok   = host_en && !busy;
  assign mem_re    = (rstate_q == R_FETCH) || (host_ok && !host_we);
  assign mem_raddr = (rstate_q == R_FETCH) ? raddr_q : host_addr;
  assign mem_we    = (wfire && !wbad_q) || (host_ok && host_we);
  assign mem_waddr = (wstate_q == W_DATA) ? waddr_q : host_addr;
  assign mem_wdata = (wstate_q == W_DATA) ? dma_write_chnl_data
                                          : host_wdata;

  fcdnn_dma64_sram #(
    .DEPTH (MEM_WORDS),
    .AW    (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata)
  );

  assign dma_read_ctrl_ready  = rctrl_rdy_q;
  assign dma_read_chnl_valid  = rvalid_q;
  assign dma_read_chnl_data   = (rvalid_q && !rbad_q) ? mem_rdata : '0;
  assign dma_write_ctrl_ready = wctrl_rdy_q;
  assign dma_write_chnl_ready = wchnl_rdy_q;
  assign host_rdata           = mem_rdata;
  assign rd_done              = rd_done_q;
  assign wr_done              = wr_done_q;
  assign err                  = err_q;

endmodule

// File: tb/tb_fcdnn_dma64_mem_server.sv
// Directed bench for the DMA memory server: streaming reads, writes,
// error paths and mid-stream reset, with hand-computed expectations.
module tb_fcdnn_dma64_mem_server;
  import fcdnn_dma_pkg::*;

  logic        clk, rst;
  logic [10:0] rd_base, wr_base;
  logic        r_cv, r_cr, r_dv, r_dr;
  logic [31:0] r_idx, r_len;
  logic [2:0]  r_sz;
  logic [63:0] r_data;
  logic        w_cv, w_cr, w_dv, w_dr;
  logic [31:0] w_idx, w_len;
  logic [2:0]  w_sz;
  logic [63:0] w_data;
  logic        host_en, host_we;
  logic [10:0] host_addr;
  logic [63:0] host_wdata, host_rdata;
  logic        busy, rd_done, wr_done, err, err_clr;

  int vec = 0;
  int miss = 0;

  logic [63:0] rd_q[$];
  int rd_dones, rd_lat, rd_hold_err;
  bit rd_to;
  int wr_acc, wr_dones;
  bit wr_to;

  fcdnn_dma64_mem_server dut (
    .clk                        (clk),
    .rst                        (rst),
    .rd_base                    (rd_base),
    .wr_base                    (wr_base),
    .dma_read_ctrl_valid        (r_cv),
    .dma_read_ctrl_data_index   (r_idx),
    .dma_read_ctrl_data_length  (r_len),
    .dma_read_ctrl_data_size    (r_sz),
    .dma_read_ctrl_ready        (r_cr),
    .dma_read_chnl_valid        (r_dv),
    .dma_read_chnl_data         (r_data),
    .dma_read_chnl_ready        (r_dr),
    .dma_write_ctrl_valid       (w_cv),
    .dma_write_ctrl_data_index  (w_idx),
    .dma_write_ctrl_data_length (w_len),
    .dma_write_ctrl_data_size   (w_sz),
    .dma_write_ctrl_ready       (w_cr),
    .dma_write_chnl_valid       (w_dv),
    .dma_write_chnl_data        (w_data),
    .dma_write_chnl_ready       (w_dr),
    .host_en                    (host_en),
    .host_we                    (host_we),
    .host_addr                  (host_addr),
    .host_wdata                 (host_wdata),
    .host_rdata                 (host_rdata),
    .busy                       (busy),
    .rd_done                    (rd_done),
    .wr_done                    (wr_done),
    .err                        (err),
    .err_clr                    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [63:0] d);
    host_en = 1'b1; host_we = 1'b1;
    host_addr = 11'(a); host_wdata = d;
    tick();
    host_en = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input int a, output logic [63:0] d);
    host_en = 1'b1; host_we = 1'b0; host_addr = 11'(a);
    tick();
    host_en = 1'b0;
    d = host_rdata;
  endtask

  // Issues one read request and collects the accepted beats.
  task automatic run_read(input logic [31:0] idx, input logic [31:0] len,
                          input logic [2:0] sz, input bit toggle,
                          input int stop_after);
    bit pv, fin;
    logic [63:0] pd;
    int post;
    logic [3:0] pat;
    pat = 4'b1001;
    rd_q.delete();
    rd_dones = 0; rd_lat = -1; rd_hold_err = 0;
    pv = 1'b0; fin = 1'b0; post = -1; pd = '0;
    r_idx = idx; r_len = len; r_sz = sz; r_cv = 1'b1;
    tick();
    r_cv = 1'b0;
    for (int k = 1; k < 600; k++) begin
      r_dr = toggle ? pat[k % 4] : 1'b1;
      if (pv && !(r_dv === 1'b1 && r_data === pd)) rd_hold_err++;
      if (r_dv && rd_lat < 0) rd_lat = k;
      if (rd_done) rd_dones++;
      pv = r_dv && !r_dr;
      pd = r_data;
      if (r_dv && r_dr) rd_q.push_back(r_data);
      if (stop_after > 0 && rd_q.size() == stop_after) begin
        fin = 1'b1;
        break;
      end
      if (rd_done && post < 0) post = 3;
      if (post == 0) begin
        fin = 1'b1;
        break;
      end
      if (post > 0) post--;
      tick();
    end
    rd_to = !fin;
  endtask

  task automatic run_write(input logic [31:0] idx, input logic [31:0] len,
                           input logic [2:0] sz, input logic [63:0] base);
    bit fin;
    int post, i;
    fin = 1'b0; post = -1; i = 0; wr_dones = 0;
    w_idx = idx; w_len = len; w_sz = sz; w_cv = 1'b1;
    tick();
    w_cv = 1'b0;
    for (int k = 1; k < 400; k++) begin
      w_dv = (i < int'(len));
      w_data = base + 64'(i);
      if (wr_done) wr_dones++;
      if (w_dv && w_dr) i++;
      if (wr_done && post < 0) post = 3;
      if (post == 0) begin
        fin = 1'b1;
        break;
      end
      if (post > 0) post--;
      tick();
    end
    w_dv = 1'b0;
    wr_acc = i;
    wr_to = !fin;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    got = {r_cr, w_cr, r_dv, w_dr, busy, rd_done, wr_done, err};
    vec++;
    if (got !== 8'b1100_0000) begin
      miss++;
      $display("FAIL reset_flags: got %b want 11000000", got);
    end
    vec++;
    if (r_data !== 64'd0 || host_rdata !== 64'd0) begin
      miss++;
      $display("FAIL reset_data: got %h/%h want 0/0", r_data, host_rdata);
    end
  endtask

  task automatic test_read_basic();
    logic [63:0] exp, got;
    for (int i = 0; i < NUM_BEATS_RD; i++)
      host_write(i, 64'hA5A5_0000_0000_0000 + 64'(i));
    run_read(32'd0, 32'(NUM_BEATS_RD), DMA_SIZE_64, 1'b0, 0);
    vec++;
    if (rd_to || rd_q.size() != NUM_BEATS_RD) begin
      miss++;
      $display("FAIL rd_count: got %0d timeout %0d want 28", rd_q.size(), rd_to);
    end
    for (int i = 0; i < NUM_BEATS_RD; i++) begin
      exp = 64'hA5A5_0000_0000_0000 + 64'(i);
      got = (i < rd_q.size()) ? rd_q[i] : 'x;
      vec++;
      if (got !== exp) begin
        miss++;
        $display("FAIL rd_beat%0d: got %h want %h", i, got, exp);
      end
    end
    vec++;
    if (rd_lat != 2) begin
      miss++;
      $display("FAIL rd_latency: got %0d want 2", rd_lat);
    end
    vec++;
    if (rd_dones != 1 || err !== 1'b0 || busy !== 1'b0) begin
      miss++;
      $display("FAIL rd_done_err: got done %0d err %b busy %b want 1 0 0",
               rd_dones, err, busy);
    end
  endtask

  task automatic test_read_backpressure();
    int bad;
    bad = 0;
    run_read(32'd0, 32'(NUM_BEATS_RD), DMA_SIZE_64, 1'b1, 0);
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== 64'hA5A5_0000_0000_0000 + 64'(i)) bad++;
    vec++;
    if (rd_to || rd_q.size() != NUM_BEATS_RD || bad != 0) begin
      miss++;
      $display("FAIL bp_count: got %0d beats %0d wrong want 28 0",
               rd_q.size(), bad);
    end
    vec++;
    if (rd_hold_err != 0 || rd_dones != 1) begin
      miss++;
      $display("FAIL bp_hold: got %0d unstable %0d done want 0 1",
               rd_hold_err, rd_dones);
    end
  endtask

  task automatic test_write();
    logic [63:0] d;
    wr_base = 11'd0;
    run_write(32'd100, 32'(NUM_BEATS_WR), DMA_SIZE_64, 64'd1);
    vec++;
    if (wr_to || wr_acc != NUM_BEATS_WR || wr_dones != 1 || err !== 1'b0) begin
      miss++;
      $display("FAIL wr_hs: got acc %0d done %0d err %b want 15 1 0",
               wr_acc, wr_dones, err);
    end
    for (int i = 0; i < NUM_BEATS_WR; i++) begin
      host_read(100 + i, d);
      vec++;
      if (d !== 64'(i + 1)) begin
        miss++;
        $display("FAIL wr_mem%0d: got %h want %h", 100 + i, d, 64'(i + 1));
      end
    end
  endtask

  task automatic test_read_edge();
    run_read(32'd0, 32'd0, DMA_SIZE_64, 1'b0, 0);
    vec++;
    if (rd_to || rd_q.size() != 0 || rd_lat != -1 || rd_dones != 1) begin
      miss++;
      $display("FAIL rd_len0: got beats %0d valid_at %0d done %0d want 0 -1 1",
               rd_q.size(), rd_lat, rd_dones);
    end
    run_read(32'd0, 32'd4, 3'd2, 1'b0, 0);
    vec++;
    if (err !== 1'b1 || rd_dones != 1) begin
      miss++;
      $display("FAIL rd_bad_err: got err %b done %0d want 1 1", err, rd_dones);
    end
    vec++;
    if (rd_to || rd_q.size() != 4 ||
        (rd_q.size() == 4 && (rd_q[0] | rd_q[1] | rd_q[2] | rd_q[3]) !== 64'd0)) begin
      miss++;
      $display("FAIL rd_bad_beats: got %0d beats want 4 zero beats", rd_q.size());
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vec++;
    if (err !== 1'b0) begin
      miss++;
      $display("FAIL err_clr: got %b want 0", err);
    end
  endtask

  task automatic test_write_oob();
    logic [63:0] d;
    for (int i = 0; i < 8; i++)
      host_write(2040 + i, 64'hBEEF_0000_0000_0000 + 64'(i));
    run_write(32'd2040, 32'(NUM_BEATS_WR), DMA_SIZE_64, 64'hDEAD_0000_0000_0000);
    vec++;
    if (wr_to || err !== 1'b1 || wr_acc != NUM_BEATS_WR || wr_dones != 1) begin
      miss++;
      $display("FAIL wr_oob: got err %b acc %0d done %0d want 1 15 1",
               err, wr_acc, wr_dones);
    end
    for (int i = 0; i < 8; i++) begin
      host_read(2040 + i, d);
      vec++;
      if (d !== 64'hBEEF_0000_0000_0000 + 64'(i)) begin
        miss++;
        $display("FAIL oob_mem%0d: got %h want %h", 2040 + i, d,
                 64'hBEEF_0000_0000_0000 + 64'(i));
      end
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    int bad;
    run_read(32'd0, 32'(NUM_BEATS_RD), DMA_SIZE_64, 1'b0, 10);
    #1;
    rst = 1'b0;
    #1;
    got = {r_cr, w_cr, r_dv, w_dr, busy, rd_done, wr_done, err};
    vec++;
    if (got !== 8'b1100_0000 || r_data !== 64'd0) begin
      miss++;
      $display("FAIL mid_reset: got %b data %h want 11000000 0", got, r_data);
    end
    tick();
    rst = 1'b1;
    tick();
    run_read(32'd0, 32'(NUM_BEATS_RD), DMA_SIZE_64, 1'b0, 0);
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== 64'hA5A5_0000_0000_0000 + 64'(i)) bad++;
    vec++;
    if (rd_to || rd_q.size() != NUM_BEATS_RD || bad != 0 || rd_dones != 1) begin
      miss++;
      $display("FAIL post_reset_rd: got %0d beats %0d wrong %0d done",
               rd_q.size(), bad, rd_dones);
    end
  endtask

  initial begin
    rst = 1'b0;
    rd_base = '0; wr_base = '0;
    r_cv = 1'b0; r_idx = '0; r_len = '0; r_sz = DMA_SIZE_64; r_dr = 1'b1;
    w_cv = 1'b0; w_idx = '0; w_len = '0; w_sz = DMA_SIZE_64;
    w_dv = 1'b0; w_data = '0;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    err_clr = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_read_basic();
    test_read_backpressure();
    test_write();
    test_read_edge();
    test_write_oob();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
